// File: rtl/stream_credit_tx_pkg.sv
// Shared types and helpers for the credit-based link transmitter.
package stream_credit_tx_pkg;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_cnt_e;

  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/stream_credit_counter.sv
// Saturating credit counter: starts full, decrements per send, increments per returned credit.
module stream_credit_counter
  import stream_credit_tx_pkg::*;
#(
  parameter int NumCredits = 4,
  parameter int CntW       = cnt_width(NumCredits)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            dec_i,
  input  logic            inc_i,
  output logic [CntW-1:0] cnt_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            overflow_o
);

  localparam logic [CntW-1:0] Max = CntW'(NumCredits);

  logic [CntW-1:0] cnt_q;

  assign cnt_o      = cnt_q;
  assign full_o     = (cnt_q == Max);
  assign empty_o    = (cnt_q == '0);
  // A credit with nothing outstanding means the partner is out of sync.
  assign overflow_o = inc_i && !dec_i && full_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                           cnt_q <= Max;
    else if (dec_i && !inc_i)            cnt_q <= cnt_q - 1'b1;
    else if (inc_i && !dec_i && !full_o) cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/stream_credit_tx.sv
// Credit-gated transmitter: 2-entry skid buffer feeding a registered ready-less link.
module stream_credit_tx
  import stream_credit_tx_pkg::*;
#(
  parameter type T          = logic,
  parameter int  NumCredits = 4,
  parameter int  CntW       = cnt_width(NumCredits)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            flush_i,
  input  logic            valid_i,
  output logic            ready_o,
  input  T                data_i,
  output logic            tx_valid_o,
  output T                tx_data_o,
  input  logic            credit_i,
  output logic [CntW-1:0] credits_o,
  output logic            idle_o,
  output logic            err_o
);

  buf_cnt_e cnt_q;
  T         buf_a, buf_b;   // buf_a is always the oldest entry
  logic     accept, send;
  logic     cr_full, cr_empty, cr_overflow;

  assign ready_o = (cnt_q != BUF_FULL) && !flush_i;
  assign accept  = valid_i && ready_o;
  // Registered credit count only, so a returned credit takes effect a cycle later.
  assign send    = (cnt_q != BUF_EMPTY) && !cr_empty && !flush_i;
  assign idle_o  = (cnt_q == BUF_EMPTY) && cr_full;

  stream_credit_counter #(
    .NumCredits(NumCredits),
    .CntW      (CntW)
  ) u_credits (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .dec_i     (send),
    .inc_i     (credit_i),
    .cnt_o     (credits_o),
    .full_o    (cr_full),
    .empty_o   (cr_empty),
    .overflow_o(cr_overflow)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= BUF_EMPTY;
      buf_a <= '0;
      buf_b <= '0;
    end else if (flush_i) begin
      cnt_q <= BUF_EMPTY;
    end else begin
      case ({accept, send})
        2'b10: begin
          if (cnt_q == BUF_EMPTY) buf_a <= data_i;
          else                    buf_b <= data_i;
          cnt_q <= (cnt_q == BUF_EMPTY) ? BUF_ONE : BUF_FULL;
        end
        2'b01: begin
          buf_a <= buf_b;
          cnt_q <= (cnt_q == BUF_FULL) ? BUF_ONE : BUF_EMPTY;
        end
        2'b11: begin
          if (cnt_q == BUF_ONE) begin
            buf_a <= data_i;
          end else begin
            buf_a <= buf_b;
            buf_b <= data_i;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      err_o      <= 1'b0;
    end else begin
      tx_valid_o <= send;
      if (send) tx_data_o <= buf_a;
      if (cr_overflow) err_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_stream_credit_tx.sv
// Directed scoreboard bench for stream_credit_tx (NumCredits=4, 8-bit payload).
module tb_stream_credit_tx;

  logic       clk = 1'b0;
  logic       rst, flush, valid, ready, tx_valid, idle, err;
  logic [7:0] data, tx_data;
  logic [2:0] credits;
  logic       credit_man, credit_loop, loop_en;
  logic       credit;

  assign credit = credit_man | credit_loop;

  stream_credit_tx #(
    .T         (logic [7:0]),
    .NumCredits(4)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .flush_i   (flush),
    .valid_i   (valid),
    .ready_o   (ready),
    .data_i    (data),
    .tx_valid_o(tx_valid),
    .tx_data_o (tx_data),
    .credit_i  (credit),
    .credits_o (credits),
    .idle_o    (idle),
    .err_o     (err)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  logic [7:0] exp_q[$];
  bit         s3       = 1'b0;
  int         s3_cnt   = 0;
  int         s3_first = -1;
  int         s3_last  = -1;
  int         max_cred = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: every link word must match the oldest outstanding expectation.
  initial forever begin
    @(negedge clk);
    if (int'(credits) > max_cred) max_cred = int'(credits);
    if (!rst && tx_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL tx_unexpected: got %0h expected no word", tx_data);
      end else begin
        check("tx_data", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
      if (s3) begin
        if (s3_first < 0) s3_first = cyc;
        s3_last = cyc;
        s3_cnt++;
      end
    end
  end

  // Loopback: a credit returns in the cycle after each link word.
  initial begin
    logic tvs;
    credit_loop = 1'b0;
    forever begin
      @(negedge clk);
      tvs = tx_valid;
      @(posedge clk);
      #1;
      credit_loop = loop_en & tvs;
    end
  end

  task automatic push(input logic [7:0] w, input bit expect_tx);
    logic acc;
    int   n;
    data  = w;
    valid = 1'b1;
    if (expect_tx) exp_q.push_back(w);
    n = 0;
    forever begin
      @(negedge clk);
      acc = ready;
      @(posedge clk);
      #1;
      if (acc) break;
      n++;
      if (n > 50) begin
        n_checks++;
        n_fail++;
        $display("FAIL push_timeout: word %0h never accepted", w);
        break;
      end
    end
    valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_credit();
    credit_man = 1'b1;
    cycles(1);
    credit_man = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid = 1'b0; data = '0;
    credit_man = 1'b0; loop_en = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("rst_tx_data", {24'h0, tx_data}, 32'h0);
    check("rst_credits", {29'h0, credits}, 32'h4);
    check("rst_err", {31'h0, err}, 32'h0);
    check("rst_idle", {31'h0, idle}, 32'h1);
    check("rst_ready", {31'h0, ready}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: six words, four credits
    for (int i = 0; i < 6; i++) push(8'h10 + 8'(i), 1'b1);
    cycles(3);
    @(negedge clk);
    check("s1_credits", {29'h0, credits}, 32'h0);
    check("s1_ready", {31'h0, ready}, 32'h0);
    check("s1_pending", exp_q.size(), 32'd2);
    @(posedge clk);
    #1;

    // 2: one credit in cycle c -> 0x14 and ready at c+2
    credit_man = 1'b1;
    cycles(1);
    credit_man = 1'b0;
    @(negedge clk);
    check("s2_c1_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("s2_c1_ready", {31'h0, ready}, 32'h0);
    check("s2_c1_credits", {29'h0, credits}, 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("s2_c2_tx_valid", {31'h0, tx_valid}, 32'h1);
    check("s2_c2_ready", {31'h0, ready}, 32'h1);
    check("s2_c2_credits", {29'h0, credits}, 32'h0);
    @(posedge clk);
    #1;
    cycles(2);
    pulse_credit();
    cycles(3);
    check("s2_drained", exp_q.size(), 32'd0);
    for (int i = 0; i < 4; i++) pulse_credit();
    @(negedge clk);
    check("s2_credits_restored", {29'h0, credits}, 32'h4);
    check("s2_idle", {31'h0, idle}, 32'h1);
    @(posedge clk);
    #1;

    // 3: 100 words with credit loopback
    loop_en = 1'b1;
    s3 = 1'b1;
    max_cred = 0;
    for (int i = 0; i < 100; i++) push(8'(i), 1'b1);
    cycles(10);
    s3 = 1'b0;
    loop_en = 1'b0;
    cycles(2);
    check("s3_count", s3_cnt, 32'd100);
    check("s3_no_gaps", s3_last - s3_first, 32'd99);
    check("s3_max_credits", max_cred, 32'd4);
    check("s3_err", {31'h0, err}, 32'h0);
    check("s3_credits", {29'h0, credits}, 32'h4);

    // 4: flush a full buffer while 0xAA is offered
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i), 1'b1);
    push(8'h30, 1'b0);
    push(8'h31, 1'b0);
    cycles(2);
    check("s4_pre_ready", {31'h0, ready}, 32'h0);
    flush = 1'b1; valid = 1'b1; data = 8'hAA;
    @(negedge clk);
    check("s4_flush_ready", {31'h0, ready}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0; valid = 1'b0;
    cycles(2);
    check("s4_credits", {29'h0, credits}, 32'h0);
    check("s4_ready", {31'h0, ready}, 32'h1);
    pulse_credit();
    cycles(2);
    check("s4_credit_idle_buf", {29'h0, credits}, 32'h1);
    push(8'h40, 1'b1);
    cycles(3);
    check("s4_after_send", {29'h0, credits}, 32'h0);
    check("s4_drained", exp_q.size(), 32'd0);

    // 6: send and credit together at credits=1
    push(8'h50, 1'b1);
    push(8'h51, 1'b1);
    cycles(1);
    credit_man = 1'b1;
    cycles(2);
    credit_man = 1'b0;
    @(negedge clk);
    check("s6_credits_hold", {29'h0, credits}, 32'h1);
    check("s6_tx_first", {31'h0, tx_valid}, 32'h1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("s6_credits_after", {29'h0, credits}, 32'h0);
    check("s6_tx_second", {31'h0, tx_valid}, 32'h1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) pulse_credit();
    cycles(1);

    // 5: overflow credit, then reset mid-stream
    check("s5_idle", {31'h0, idle}, 32'h1);
    pulse_credit();
    cycles(3);
    check("s5_err", {31'h0, err}, 32'h1);
    check("s5_credits", {29'h0, credits}, 32'h4);
    push(8'h60, 1'b1);
    push(8'h61, 1'b0);
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("s5_rst_tx_valid", {31'h0, tx_valid}, 32'h0);
    check("s5_rst_err", {31'h0, err}, 32'h0);
    check("s5_rst_credits", {29'h0, credits}, 32'h4);
    check("s5_rst_idle", {31'h0, idle}, 32'h1);
    @(posedge clk);
    #1 rst = 1'b0;
    cycles(4);
    check("final_queue_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
